// File: rtl/proj_pkg.sv
// Shared types and constants for the MinHash datapath (k-mer buffer -> hasher).
// Optional feature macro used by the k-mer buffer: KMER_CANONICAL_EN.
package proj_pkg;

   // Geometry shared between proj_kmer_buffer and proj_hasher.
   localparam int KMER_BUFFER_HASHER_KMER_LEN  = 16;
   localparam int KMER_BUFFER_HASHER_BASE_BITS = 2;
   localparam int KMER_BUFFER_HASHER_DATA_BITS =
      KMER_BUFFER_HASHER_KMER_LEN * KMER_BUFFER_HASHER_BASE_BITS;
   localparam int KMER_BUFFER_CNT_BITS         = 32;

   typedef logic [KMER_BUFFER_HASHER_BASE_BITS-1:0] base_t;
   typedef logic [KMER_BUFFER_HASHER_DATA_BITS-1:0] kmer_t;

   // FILL: collecting the first KMER_LEN bases of a sequence.
   // STREAM: window full, every accepted base yields a k-mer.
   typedef enum logic [0:0] {
      KB_FILL   = 1'b0,
      KB_STREAM = 1'b1
   } kbuf_state_t;

   // Nucleotide codes. With 2-bit codes the complement is the bitwise inverse.
   localparam base_t BASE_A = base_t'(0);
   localparam base_t BASE_C = base_t'(1);
   localparam base_t BASE_G = base_t'(2);
   localparam base_t BASE_T = base_t'(3);

   // Watson-Crick complement of a 2-bit base code (A<->T, C<->G).
   function automatic base_t base_complement(input base_t b);
      return ~b;
   endfunction

endpackage

// File: rtl/proj_kmer_buffer_if.sv
// Handshake bundle of the k-mer buffer: base input port, sequence control,
// k-mer output port and the hand-off counter.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid && ready are both high; the producer holds data stable while
// valid && !ready; ready may depend combinationally on the consumer's ready.
interface proj_kmer_buffer_if #(
   parameter int BASE_BITS = proj_pkg::KMER_BUFFER_HASHER_BASE_BITS,
   parameter int DATA_BITS = proj_pkg::KMER_BUFFER_HASHER_DATA_BITS,
   parameter int CNT_BITS  = proj_pkg::KMER_BUFFER_CNT_BITS
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic [BASE_BITS-1:0] in_base;
   logic                 in_last;
   logic                 seq_clear;
   logic                 kmer_valid;
   logic                 kmer_ready;
   logic [DATA_BITS-1:0] kmer;
   logic                 kmer_last;
   logic [CNT_BITS-1:0]  kmer_cnt;

   // Buffer side.
   modport slave (
      input  in_valid, in_base, in_last, seq_clear, kmer_ready,
      output in_ready, kmer_valid, kmer, kmer_last, kmer_cnt
   );

   // Upstream/downstream side (base source and hasher).
   modport master (
      output in_valid, in_base, in_last, seq_clear, kmer_ready,
      input  in_ready, kmer_valid, kmer, kmer_last, kmer_cnt
   );

endinterface

// File: rtl/proj_kmer_window.sv
// Sliding base window and fill counter of the k-mer buffer.
// win_nxt is the k-mer that results if the current base is shifted in now;
// the top module registers it when it emits.
// With KMER_CANONICAL_EN defined, a reverse-complement window runs alongside
// and win_nxt is the unsigned minimum of the two strands.
module proj_kmer_window #(
   parameter int KMER_LEN  = 16,
   parameter int BASE_BITS = 2,
   parameter int DATA_BITS = KMER_LEN * BASE_BITS,
   parameter int FILL_BITS = (KMER_LEN > 1) ? $clog2(KMER_LEN) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,     // drop window and fill count
   input  logic                 shift,     // a base is accepted this cycle
   input  logic                 restart,   // accepted base ends the sequence
   input  logic                 fill_en,   // count accepted bases (FILL phase)
   input  logic [BASE_BITS-1:0] base,
   output logic [DATA_BITS-1:0] win_nxt,
   output logic                 fill_done  // this accept completes the window
);

   localparam int KEEP_BITS = DATA_BITS - BASE_BITS;

   // Only the newest KMER_LEN-1 bases are stored: the oldest base of a full
   // window is shifted out by the very accept that would need it, so it only
   // ever appears in the combinational k-mer.
   logic [KEEP_BITS-1:0] fwd_q, fwd_d;
   logic [DATA_BITS-1:0] fwd_shift;
   logic [FILL_BITS-1:0] fill_q, fill_d;

   assign fwd_shift = {fwd_q, base};
   assign fill_done = (fill_q == FILL_BITS'(KMER_LEN - 1));

   // Next forward window and fill count.
   always_comb begin
      fwd_d  = fwd_q;
      fill_d = fill_q;
      if (clear) begin
         fwd_d  = '0;
         fill_d = '0;
      end else if (shift) begin
         if (restart) begin
            fwd_d  = '0;
            fill_d = '0;
         end else begin
            fwd_d = fwd_shift[KEEP_BITS-1:0];
            if (fill_en) begin
               fill_d = fill_done ? '0 : fill_q + FILL_BITS'(1);
            end
         end
      end
   end

   // Forward window and fill count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_q  <= '0;
         fill_q <= '0;
      end else begin
         fwd_q  <= fwd_d;
         fill_q <= fill_d;
      end
   end

`ifdef KMER_CANONICAL_EN
   if (BASE_BITS != 2) begin : g_base_bits_check
      $error("proj_kmer_window: canonical k-mers need BASE_BITS == 2");
   end

   // The reverse complement grows from the MSB end: the newest base,
   // complemented, becomes the oldest base of the opposite strand. As with
   // the forward window, the base that would fall off the LSB end is not kept.
   logic [KEEP_BITS-1:0] rc_q, rc_d;
   logic [DATA_BITS-1:0] rc_shift;

   assign rc_shift = {~base, rc_q};

   // Next reverse-complement window and canonical selection.
   always_comb begin
      rc_d = rc_q;
      if (clear) begin
         rc_d = '0;
      end else if (shift) begin
         rc_d = restart ? '0 : rc_shift[DATA_BITS-1:BASE_BITS];
      end
      win_nxt = (rc_shift < fwd_shift) ? rc_shift : fwd_shift;
   end

   // Reverse-complement window register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc_q <= '0;
      end else begin
         rc_q <= rc_d;
      end
   end
`else
   assign win_nxt = fwd_shift;
`endif

endmodule

// File: rtl/proj_kmer_buffer.sv
// Streaming k-mer producer ahead of proj_hasher. Accepts one base per
// handshake, keeps a KMER_LEN sliding window (proj_kmer_window) and, once the
// window is full, emits every complete k-mer through a one-deep output
// register. Oldest base sits in the k-mer MSBs.
// Optional feature macro: KMER_CANONICAL_EN (emit min(forward, reverse
// complement) instead of the forward k-mer).
module proj_kmer_buffer
   import proj_pkg::*;
#(
   parameter int KMER_LEN  = proj_pkg::KMER_BUFFER_HASHER_KMER_LEN,
   parameter int BASE_BITS = proj_pkg::KMER_BUFFER_HASHER_BASE_BITS,
   parameter int CNT_BITS  = proj_pkg::KMER_BUFFER_CNT_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   proj_kmer_buffer_if.slave   bus,
   output kbuf_state_t         dbg_state
);

   localparam int DATA_BITS = KMER_LEN * BASE_BITS;

   kbuf_state_t          state_q, state_d;
   logic [DATA_BITS-1:0] kmer_q, kmer_d;
   logic                 kmer_valid_q, kmer_valid_d;
   logic                 kmer_last_q, kmer_last_d;
   logic [CNT_BITS-1:0]  kmer_cnt_q, kmer_cnt_d;

   logic                 in_ready;
   logic                 accept;
   logic                 take;
   logic                 emit;
   logic                 fill_done;
   logic [DATA_BITS-1:0] win_nxt;

   // The output register frees up in the same cycle it is taken, so a new
   // base can be accepted every cycle while downstream keeps ready high.
   assign in_ready = !bus.seq_clear && (!kmer_valid_q || bus.kmer_ready);
   assign accept   = bus.in_valid && in_ready;
   assign take     = kmer_valid_q && bus.kmer_ready;
   assign emit     = accept && ((state_q == KB_STREAM) || fill_done);

   proj_kmer_window #(
      .KMER_LEN  (KMER_LEN),
      .BASE_BITS (BASE_BITS),
      .DATA_BITS (DATA_BITS)
   ) u_window (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (bus.seq_clear),
      .shift     (accept),
      .restart   (bus.in_last),
      .fill_en   (state_q == KB_FILL),
      .base      (bus.in_base),
      .win_nxt   (win_nxt),
      .fill_done (fill_done)
   );

   // Sequence FSM: FILL until the window holds KMER_LEN bases, then STREAM
   // until the sequence ends or is aborted.
   always_comb begin
      state_d = state_q;
      if (bus.seq_clear) begin
         state_d = KB_FILL;
      end else if (accept) begin
         if (bus.in_last) begin
            state_d = KB_FILL;
         end else if ((state_q == KB_FILL) && fill_done) begin
            state_d = KB_STREAM;
         end
      end
   end

   // Output register: load on emit, drop on a take without a replacement,
   // hold otherwise; an abort discards any pending k-mer.
   always_comb begin
      kmer_d       = kmer_q;
      kmer_valid_d = kmer_valid_q;
      kmer_last_d  = kmer_last_q;
      kmer_cnt_d   = kmer_cnt_q + {{(CNT_BITS-1){1'b0}}, take};
      if (bus.seq_clear) begin
         kmer_valid_d = 1'b0;
         kmer_last_d  = 1'b0;
      end else if (emit) begin
         kmer_d       = win_nxt;
         kmer_valid_d = 1'b1;
         kmer_last_d  = bus.in_last;
      end else if (take) begin
         kmer_valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= KB_FILL;
         kmer_q       <= '0;
         kmer_valid_q <= 1'b0;
         kmer_last_q  <= 1'b0;
         kmer_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         kmer_q       <= kmer_d;
         kmer_valid_q <= kmer_valid_d;
         kmer_last_q  <= kmer_last_d;
         kmer_cnt_q   <= kmer_cnt_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.kmer_valid = kmer_valid_q;
   assign bus.kmer       = kmer_q;
   assign bus.kmer_last  = kmer_last_q;
   assign bus.kmer_cnt   = kmer_cnt_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_proj_kmer_buffer.sv
// Bench for proj_kmer_buffer (KMER_LEN=16, BASE_BITS=2). A negedge monitor
// keeps a sequence-level reference model (bases seen per sequence, expected
// k-mer queue, hand-off count) and checks every cycle; the scenario tasks add
// directed checks on known values.
module tb_proj_kmer_buffer;
  import proj_pkg::*;

  logic clk;
  logic rst_n;
  kbuf_state_t dbg_state;

  proj_kmer_buffer_if bus ();

  proj_kmer_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [1:0]  seq_q[$];
  int          seq_n   = 0;
  logic [31:0] exp_cnt = 0;

  function automatic logic [31:0] ref_kmer(input logic [1:0] b [16]);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < 16; i++) f = (f << 2) | {30'h0, b[i]};
`ifdef KMER_CANONICAL_EN
    begin
      logic [31:0] r;
      r = 32'h0;
      for (int i = 15; i >= 0; i--) f = f; // keep forward untouched
      for (int i = 15; i >= 0; i--) r = (r << 2) | {30'h0, 2'd3 - b[i]};
      if (r < f) f = r;
    end
`endif
    return f;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_last_q.delete();
      seq_q.delete();
      seq_n   = 0;
      exp_cnt = 0;
    end else begin
      logic m_valid;
      logic m_ready;
      m_valid = (exp_q.size() != 0);
      m_ready = !bus.seq_clear && (!m_valid || bus.kmer_ready);
      n_cmp++;
      if (bus.kmer_valid !== m_valid) begin
        n_fail++;
        $display("FAIL mon_valid: got %b expected %b at %0t", bus.kmer_valid, m_valid, $time);
      end
      n_cmp++;
      if (bus.in_ready !== m_ready) begin
        n_fail++;
        $display("FAIL mon_in_ready: got %b expected %b at %0t", bus.in_ready, m_ready, $time);
      end
      n_cmp++;
      if (bus.kmer_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL mon_cnt: got %0d expected %0d at %0t", bus.kmer_cnt, exp_cnt, $time);
      end
      if (m_valid && bus.kmer_ready) begin
        n_cmp++;
        if (bus.kmer !== exp_q[0] || bus.kmer_last !== exp_last_q[0]) begin
          n_fail++;
          $display("FAIL mon_kmer: got %h/%b expected %h/%b at %0t",
                   bus.kmer, bus.kmer_last, exp_q[0], exp_last_q[0], $time);
        end
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        exp_cnt = exp_cnt + 1;
      end
      if (bus.seq_clear) begin
        exp_q.delete();
        exp_last_q.delete();
        seq_q.delete();
        seq_n = 0;
      end else if (bus.in_valid && m_ready) begin
        seq_q.push_back(bus.in_base);
        if (seq_q.size() > 16) void'(seq_q.pop_front());
        seq_n++;
        if (seq_n >= 16) begin
          logic [1:0] w [16];
          for (int i = 0; i < 16; i++) w[i] = seq_q[i];
          exp_q.push_back(ref_kmer(w));
          exp_last_q.push_back(bus.in_last);
        end
        if (bus.in_last) begin
          seq_q.delete();
          seq_n = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] b, input logic l);
    int budget;
    budget = 200;
    bus.in_valid = 1'b1;
    bus.in_base  = b;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_base = 2'd0;
    bus.in_last = 1'b0;
    bus.seq_clear = 1'b0;
    bus.kmer_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.kmer_valid !== 1'b0 || bus.kmer !== 32'h0 || bus.kmer_last !== 1'b0 ||
        bus.kmer_cnt !== 32'h0 || bus.in_ready !== 1'b1 || dbg_state !== KB_FILL) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b k=%h l=%b c=%0d r=%b s=%0d expected 0,0,0,0,1,0",
               bus.kmer_valid, bus.kmer, bus.kmer_last, bus.kmer_cnt, bus.in_ready, dbg_state);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_fill();
    logic [1:0] fb [16];
    fb = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0,
           2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 16; i++) begin
      send(fb[i], 1'b0);
      if (i == 14) begin
        n_cmp++;
        if (bus.kmer_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_early: got kmer_valid=%b expected 0", bus.kmer_valid);
        end
      end
    end
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== 32'hab1020c5 || bus.kmer_last !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_kmer: got %b/%h/%b expected 1/ab1020c5/0",
               bus.kmer_valid, bus.kmer, bus.kmer_last);
    end
  endtask

  task automatic test_stream();
    send(2'd3, 1'b0);
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== 32'hac408317) begin
      n_fail++;
      $display("FAIL stream_kmer: got %b/%h expected 1/ac408317", bus.kmer_valid, bus.kmer);
    end
    idle(1);
    n_cmp++;
    if (bus.kmer_cnt !== 32'd2 || bus.kmer_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_cnt: got cnt=%0d v=%b expected 2/0", bus.kmer_cnt, bus.kmer_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  b1, b2;
    logic [31:0] held, want;
    b1 = 2'($urandom_range(0, 3));
    b2 = 2'($urandom_range(0, 3));
    bus.kmer_ready = 1'b0;
    send(b1, 1'b0);
    held = bus.kmer;
    want = (32'hac408317 << 2) | {30'h0, b1};
    n_cmp++;
    if (held !== want) begin
      n_fail++;
      $display("FAIL bp_first: got %h expected %h", held, want);
    end
    bus.in_valid = 1'b1;
    bus.in_base  = b2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.kmer_valid !== 1'b1 || bus.kmer !== held) begin
        n_fail++;
        $display("FAIL bp_hold: got r=%b v=%b k=%h expected 0/1/%h", bus.in_ready,
                 bus.kmer_valid, bus.kmer, held);
      end
    end
    @(posedge clk);
    #1;
    bus.kmer_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    want = (held << 2) | {30'h0, b2};
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== want || bus.kmer_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL bp_release: got %b/%h/%0d expected 1/%h/3", bus.kmer_valid, bus.kmer,
               bus.kmer_cnt, want);
    end
  endtask

  task automatic test_short_seq();
    send(2'($urandom_range(0, 3)), 1'b1);
    for (int i = 0; i < 10; i++) send(2'($urandom_range(0, 3)), (i == 9));
    idle(1);
    n_cmp++;
    if (bus.kmer_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL short_no_emit: got kmer_valid=%b expected 0", bus.kmer_valid);
    end
    for (int i = 0; i < 16; i++) begin
      send(2'($urandom_range(0, 3)), 1'b0);
      if (i == 14) begin
        n_cmp++;
        if (bus.kmer_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL short_refill_early: got kmer_valid=%b expected 0", bus.kmer_valid);
        end
      end
    end
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer_last !== 1'b0) begin
      n_fail++;
      $display("FAIL short_refill: got v=%b l=%b expected 1/0", bus.kmer_valid, bus.kmer_last);
    end
  endtask

  task automatic test_last_clear();
    logic [31:0] cnt_before;
    logic [1:0]  w [16];
    send(2'($urandom_range(0, 3)), 1'b1);
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer_last !== 1'b1) begin
      n_fail++;
      $display("FAIL last_flag: got v=%b l=%b expected 1/1", bus.kmer_valid, bus.kmer_last);
    end
    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
    idle(1);
    cnt_before = bus.kmer_cnt;
    bus.seq_clear = 1'b1;
    idle(1);
    bus.seq_clear = 1'b0;
    n_cmp++;
    if (bus.kmer_cnt !== cnt_before || dbg_state !== KB_FILL) begin
      n_fail++;
      $display("FAIL clear_keep_cnt: got cnt=%0d st=%0d expected %0d/0", bus.kmer_cnt,
               dbg_state, cnt_before);
    end
    for (int i = 0; i < 16; i++) begin
      w[i] = 2'($urandom_range(0, 3));
      send(w[i], 1'b0);
      if (i == 14) begin
        n_cmp++;
        if (bus.kmer_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_refill_early: got kmer_valid=%b expected 0", bus.kmer_valid);
        end
      end
    end
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== ref_kmer(w)) begin
      n_fail++;
      $display("FAIL clear_refill: got %b/%h expected 1/%h", bus.kmer_valid, bus.kmer, ref_kmer(w));
    end
    send(2'($urandom_range(0, 3)), 1'b1);
  endtask

  task automatic test_canonical();
    logic [31:0] want_t;
`ifdef KMER_CANONICAL_EN
    want_t = 32'h00000000;
`else
    want_t = 32'hffffffff;
`endif
    for (int i = 0; i < 16; i++) send(BASE_T, (i == 15));
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== want_t) begin
      n_fail++;
      $display("FAIL canon_all_t: got %b/%h expected 1/%h", bus.kmer_valid, bus.kmer, want_t);
    end
    for (int i = 0; i < 16; i++) send(BASE_A, (i == 15));
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== 32'h00000000) begin
      n_fail++;
      $display("FAIL canon_all_a: got %b/%h expected 1/00000000", bus.kmer_valid, bus.kmer);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_base    = 2'($urandom_range(0, 3));
      bus.in_last    = ($urandom_range(0, 24) == 0);
      bus.kmer_ready = ($urandom_range(0, 3) != 0);
      bus.seq_clear  = ($urandom_range(0, 49) == 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.seq_clear  = 1'b0;
    bus.kmer_ready = 1'b1;
    idle(3);
    n_cmp++;
    if (bus.kmer_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got kmer_valid=%b expected 0", bus.kmer_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] w [16];
    for (int i = 0; i < 5; i++) send(2'($urandom_range(0, 3)), 1'b0);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (bus.kmer_valid !== 1'b0 || bus.kmer !== 32'h0 || bus.kmer_cnt !== 32'h0 ||
        bus.in_ready !== 1'b1 || dbg_state !== KB_FILL) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b k=%h c=%0d r=%b s=%0d expected 0,0,0,1,0",
               bus.kmer_valid, bus.kmer, bus.kmer_cnt, bus.in_ready, dbg_state);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w[i] = 2'($urandom_range(0, 3));
      send(w[i], (i == 15));
    end
    n_cmp++;
    if (bus.kmer_valid !== 1'b1 || bus.kmer !== ref_kmer(w) || bus.kmer_last !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_kmer: got %b/%h/%b expected 1/%h/1", bus.kmer_valid,
               bus.kmer, bus.kmer_last, ref_kmer(w));
    end
    idle(2);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_backpressure();
    test_short_seq();
    test_last_clear();
    test_canonical();
    test_random();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
